vx_commit_arb: RTL and testbench
================================

// Module: VX_commit_arb
// PURPOSE
// - Shares one commit/writeback port (VX_commit_if-style data_t) among NUM_REQS execute-unit commit streams.
// - Packet-atomic round-robin: a multi-packet commit (sop..eop, successive pid) is never interleaved with another requester.
// - One registered output stage between the execute-unit commit outputs and the commit stage.
// PARAMETERS
// - NUM_REQS   4    number of requesting commit streams (>=1; 1 = pass-through with register)
// - DATAW      64   width of one flattened data_t packet; bit[1]=sop, bit[0]=eop (struct tail: pid,sop,eop)
// - OUT_REG    1    reserved, must be 1 (output register always present)
// PORTS
// - clk             in   1               clock
// - reset_n         in   1               asynchronous active-low reset
// - valid_in        in   NUM_REQS        per-requester packet valid
// - data_in         in   NUM_REQS*DATAW  per-requester packet, requester i at [i*DATAW +: DATAW]
// - ready_in        out  NUM_REQS        per-requester accept (one-hot or zero)
// - valid_out       out  1               packet valid to commit stage
// - data_out        out  DATAW           selected packet, registered
// - sel_out         out  log2up(NUM_REQS) index of requester that produced data_out
// - ready_out       in   1               commit stage accept
// BEHAVIOUR
// - Reset (async assert, sync deassert at top level): valid_out=0, data_out=0, sel_out=0, lock=0, rr pointer=0; ready_in is 0 during reset.
// - Handshake: transfer on valid&&ready at each port; valid_in must hold with stable data until ready_in[i]; valid_out holds until ready_out.
// - Pipe ready: pready = !valid_out || ready_out (full throughput, 1 packet/cycle, latency 1 cycle in->out).
// - Grant (combinational): if lock, candidate = lock_idx only; else first valid_in at/after rr pointer, wrapping modulo NUM_REQS.
// - ready_in[i] = pready && grant[i]; ready_in never depends on valid_in of the same requester beyond the grant function.
// - On accept: data_out<=data_in[g], sel_out<=g, valid_out<=1; if pready && no grant then valid_out<=0.
// - Lock FSM, states UNLOCKED / LOCKED(idx):
//   - UNLOCKED -> LOCKED(g): accepted packet has sop=1, eop=0.
//   - LOCKED(idx) stays while packets from idx have eop=0; lock holds even while valid_in[idx]=0 (bubbles allowed).
//   - LOCKED -> UNLOCKED: accepted packet from idx has eop=1.
//   - sop=1,eop=1 single packet: no lock.
// - RR pointer: updated to (g+1) mod NUM_REQS only when an eop=1 packet is accepted; unchanged on non-eop accepts.
// - Protocol error: sop=0 accepted while UNLOCKED, or sop=1 while LOCKED -> packet still forwarded; simulation assertion fires.
// - Backpressure: ready_out=0 with valid_out=1 -> all ready_in=0, output and lock state frozen.
// - Reset mid-packet: lock dropped, in-flight output packet discarded; no partial recovery.
// CONFIGURATION
// - VX_COMMIT_ARB_PERF_EN defined: adds outputs perf_stalls[31:0] (cycles valid_out&&!ready_out) and
//   perf_conflicts[31:0] (cycles with >=2 valid_in and pready), both reset to 0, wrap at 2^32.
// - Undefined: ports and counters absent; arbitration behaviour identical.
// TESTING
// - Reset: reset_n=0 with all valid_in=1 -> ready_in=0, valid_out=0; release -> req0 granted first cycle, data_out next cycle.
// - RR fairness: NUM_REQS=4, all valid with single packets (sop=eop=1), ready_out=1 -> sel_out sequence 0,1,2,3,0,... one per cycle.
// - Atomic packet: req2 sends 3 packets (sop,-,eop) while req0/req1 valid -> sel_out 2,2,2 then 3-wrap order 0,1; no interleave.
// - Locked bubble: req1 sends sop, drops valid 2 cycles, then eop; req3 valid throughout -> ready_in[3]=0 until req1 eop accepted.
// - Backpressure: ready_out=0 for 5 cycles with valid_out=1 -> data_out stable, ready_in=0; with PERF_EN perf_stalls increments by 5.
// - Async reset mid-packet: reset_n pulsed low between sop and eop of req0 -> valid_out=0 immediately, next grant unlocked, rr=0.

Source files
------------

// File: rtl/vx_commit_arb.sv
// Packet-atomic round-robin arbiter that merges NUM_REQS commit streams onto one registered commit port.
// Optional build macro VX_COMMIT_ARB_PERF_EN adds the perf_stalls / perf_conflicts counters.
module vx_commit_arb #(
   parameter int NUM_REQS = 4,
   parameter int DATAW    = 64,
   parameter int OUT_REG  = 1,
   localparam int SELW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQS-1:0]       valid_in,
   input  logic [NUM_REQS*DATAW-1:0] data_in,
   output logic [NUM_REQS-1:0]       ready_in,
   output logic                      valid_out,
   output logic [DATAW-1:0]          data_out,
   output logic [SELW-1:0]           sel_out,
   input  logic                      ready_out
`ifdef VX_COMMIT_ARB_PERF_EN
   ,
   output logic [31:0]               perf_stalls,
   output logic [31:0]               perf_conflicts
`endif
);

   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

   lock_state_t          state, state_next;
   logic [SELW-1:0]      lock_idx, lock_idx_next;
   logic [SELW-1:0]      rr_ptr, rr_next;
   logic [SELW-1:0]      grant_idx;
   logic [NUM_REQS-1:0]  grant;
   logic [DATAW-1:0]     grant_data;
   logic                 grant_valid;
   logic                 pready;
   logic                 accept;
   logic                 pkt_sop;
   logic                 pkt_eop;

   function automatic logic [SELW-1:0] rr_offset(input logic [SELW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQS) sum = sum - NUM_REQS;
      return SELW'(sum);
   endfunction

   assign pready   = !valid_out || ready_out;
   assign accept   = pready && grant_valid;
   assign ready_in = (reset_n && pready) ? grant : '0;
   assign pkt_sop  = grant_data[1];
   assign pkt_eop  = grant_data[0];

   // Scanning downwards lets the requester closest to rr_ptr overwrite farther ones.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      grant       = '0;
      grant_data  = '0;
      if (state == LOCKED) begin
         grant_valid = valid_in[lock_idx];
         grant_idx   = lock_idx;
      end else begin
         for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (valid_in[rr_offset(rr_ptr, i)]) begin
               grant_valid = 1'b1;
               grant_idx   = rr_offset(rr_ptr, i);
            end
         end
      end
      for (int i = 0; i < NUM_REQS; i++) begin
         if (grant_valid && grant_idx == SELW'(i)) begin
            grant[i]   = 1'b1;
            grant_data = data_in[i*DATAW +: DATAW];
         end
      end
   end

   always_comb begin
      state_next    = state;
      lock_idx_next = lock_idx;
      rr_next       = rr_ptr;
      if (accept) begin
         if (pkt_eop) begin
            state_next = UNLOCKED;
            rr_next    = rr_offset(grant_idx, 1);
         end else if (state == UNLOCKED && pkt_sop) begin
            state_next    = LOCKED;
            lock_idx_next = grant_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= UNLOCKED;
         lock_idx <= '0;
         rr_ptr   <= '0;
      end else begin
         state    <= state_next;
         lock_idx <= lock_idx_next;
         rr_ptr   <= rr_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         sel_out   <= '0;
      end else if (pready) begin
         valid_out <= grant_valid;
         if (grant_valid) begin
            data_out <= grant_data;
            sel_out  <= grant_idx;
         end
      end
   end

`ifdef VX_COMMIT_ARB_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_stalls    <= '0;
         perf_conflicts <= '0;
      end else begin
         if (valid_out && !ready_out)
            perf_stalls <= perf_stalls + 32'd1;
         if (pready && ((valid_in & (valid_in - 1'b1)) != '0))
            perf_conflicts <= perf_conflicts + 32'd1;
      end
   end
`endif

`ifndef SYNTHESIS
   // Malformed packets are still forwarded; this only flags them in simulation.
   always_ff @(posedge clk) begin
      if (reset_n && accept) begin
         assert (OUT_REG == 1)
            else $error("vx_commit_arb: OUT_REG must be 1");
         assert ((state == LOCKED) ? !pkt_sop : pkt_sop)
            else $error("vx_commit_arb: sop/lock protocol violation from requester %0d", grant_idx);
      end
   end
`endif

endmodule

// File: tb/tb_vx_commit_arb.sv
// Directed testbench for vx_commit_arb: reset, round-robin order, packet locking, bubbles, backpressure, async reset.
module tb_vx_commit_arb;

   logic          clk;
   logic          reset_n;
   logic [3:0]    valid_in;
   logic [255:0]  data_in;
   logic [3:0]    ready_in;
   logic          valid_out;
   logic [63:0]   data_out;
   logic [1:0]    sel_out;
   logic          ready_out;
`ifdef VX_COMMIT_ARB_PERF_EN
   logic [31:0]   perf_stalls;
   logic [31:0]   perf_conflicts;
`endif

   int check_count = 0;
   int fail_count  = 0;

   vx_commit_arb #(.NUM_REQS(4), .DATAW(64), .OUT_REG(1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .ready_in  (ready_in),
      .valid_out (valid_out),
      .data_out  (data_out),
      .sel_out   (sel_out),
      .ready_out (ready_out)
`ifdef VX_COMMIT_ARB_PERF_EN
      ,
      .perf_stalls    (perf_stalls),
      .perf_conflicts (perf_conflicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] pkt(input logic [7:0] id, input logic sop, input logic eop);
      return {8'hC3, 46'h0, id, sop, eop};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [3:0] v, input logic [63:0] d0, input logic [63:0] d1,
                                 input logic [63:0] d2, input logic [63:0] d3);
      valid_in = v;
      data_in  = {d3, d2, d1, d0};
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      check_count++;
      assert (observed === expected)
         else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
         end
   endtask

   initial begin
      reset_n   = 1'b0;
      ready_out = 1'b1;
      apply_stimulus(4'b1111, pkt(8'h00, 1, 1), pkt(8'h01, 1, 1), pkt(8'h02, 1, 1), pkt(8'h03, 1, 1));
      tick();
      tick();
      check_output("reset ready_in", 64'(ready_in), 64'h0);
      check_output("reset valid_out", 64'(valid_out), 64'h0);
      check_output("reset data_out", data_out, 64'h0);
      check_output("reset sel_out", 64'(sel_out), 64'h0);
`ifdef VX_COMMIT_ARB_PERF_EN
      check_output("reset perf_stalls", 64'(perf_stalls), 64'h0);
`endif

      // Round-robin with every requester offering single-beat packets
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      check_output("release ready_in", 64'(ready_in), 64'h1);
      tick();
      check_output("rr0 valid_out", 64'(valid_out), 64'h1);
      check_output("rr0 sel_out", 64'(sel_out), 64'h0);
      check_output("rr0 data_out", data_out, pkt(8'h00, 1, 1));
      tick();
      check_output("rr1 sel_out", 64'(sel_out), 64'h1);
      check_output("rr1 data_out", data_out, pkt(8'h01, 1, 1));
      tick();
      check_output("rr2 sel_out", 64'(sel_out), 64'h2);
      tick();
      check_output("rr3 sel_out", 64'(sel_out), 64'h3);
      check_output("rr3 data_out", data_out, pkt(8'h03, 1, 1));
      tick();
      check_output("rr wrap sel_out", 64'(sel_out), 64'h0);

      // Backpressure for five cycles
      ready_out = 1'b0;
      #1;
      check_output("bp ready_in", 64'(ready_in), 64'h0);
      for (int i = 0; i < 5; i++) tick();
      check_output("bp valid_out", 64'(valid_out), 64'h1);
      check_output("bp data_out", data_out, pkt(8'h00, 1, 1));
      check_output("bp sel_out", 64'(sel_out), 64'h0);
      check_output("bp ready_in held", 64'(ready_in), 64'h0);
`ifdef VX_COMMIT_ARB_PERF_EN
      check_output("bp perf_stalls", 64'(perf_stalls), 64'd5);
`endif
      ready_out = 1'b1;
      #1;
      check_output("bp release ready_in", 64'(ready_in), 64'h2);
      apply_stimulus(4'b0000, '0, '0, '0, '0);
      tick();
      check_output("idle valid_out", 64'(valid_out), 64'h0);

      // Move pointer to 2, then a 3-beat packet from req2 against req0/req1
      apply_stimulus(4'b0010, '0, pkt(8'h11, 1, 1), '0, '0);
      check_output("pre ready_in", 64'(ready_in), 64'h2);
      tick();
      check_output("pre sel_out", 64'(sel_out), 64'h1);
      apply_stimulus(4'b0111, pkt(8'h20, 1, 1), pkt(8'h21, 1, 1), pkt(8'h30, 1, 0), '0);
      check_output("atomic sop ready_in", 64'(ready_in), 64'h4);
      tick();
      check_output("atomic sop sel_out", 64'(sel_out), 64'h2);
      check_output("atomic sop data_out", data_out, pkt(8'h30, 1, 0));
      apply_stimulus(4'b0111, pkt(8'h20, 1, 1), pkt(8'h21, 1, 1), pkt(8'h31, 0, 0), '0);
      check_output("atomic mid ready_in", 64'(ready_in), 64'h4);
      tick();
      check_output("atomic mid data_out", data_out, pkt(8'h31, 0, 0));
      apply_stimulus(4'b0111, pkt(8'h20, 1, 1), pkt(8'h21, 1, 1), pkt(8'h32, 0, 1), '0);
      check_output("atomic eop ready_in", 64'(ready_in), 64'h4);
      tick();
      check_output("atomic eop sel_out", 64'(sel_out), 64'h2);
      check_output("atomic eop data_out", data_out, pkt(8'h32, 0, 1));
      apply_stimulus(4'b0011, pkt(8'h20, 1, 1), pkt(8'h21, 1, 1), '0, '0);
      check_output("after atomic ready_in", 64'(ready_in), 64'h1);
      tick();
      check_output("after atomic sel_out", 64'(sel_out), 64'h0);
      check_output("after atomic data_out", data_out, pkt(8'h20, 1, 1));
      apply_stimulus(4'b0010, '0, pkt(8'h21, 1, 1), '0, '0);
      check_output("next ready_in", 64'(ready_in), 64'h2);
      tick();
      check_output("next sel_out", 64'(sel_out), 64'h1);
      apply_stimulus(4'b0000, '0, '0, '0, '0);
      tick();

      // Locked requester 1 with a two-cycle bubble while req3 waits
      apply_stimulus(4'b0010, '0, pkt(8'h50, 1, 0), '0, '0);
      check_output("lock sop ready_in", 64'(ready_in), 64'h2);
      tick();
      check_output("lock sop sel_out", 64'(sel_out), 64'h1);
      check_output("lock sop data_out", data_out, pkt(8'h50, 1, 0));
      apply_stimulus(4'b1000, '0, '0, '0, pkt(8'h40, 1, 1));
      check_output("bubble1 ready_in", 64'(ready_in), 64'h0);
      tick();
      check_output("bubble valid_out", 64'(valid_out), 64'h0);
      check_output("bubble2 ready_in", 64'(ready_in), 64'h0);
      tick();
      check_output("bubble3 ready_in", 64'(ready_in), 64'h0);
      apply_stimulus(4'b1010, '0, pkt(8'h51, 0, 1), '0, pkt(8'h40, 1, 1));
      check_output("lock eop ready_in", 64'(ready_in), 64'h2);
      tick();
      check_output("lock eop sel_out", 64'(sel_out), 64'h1);
      check_output("lock eop data_out", data_out, pkt(8'h51, 0, 1));
      apply_stimulus(4'b1000, '0, '0, '0, pkt(8'h40, 1, 1));
      check_output("unlocked ready_in", 64'(ready_in), 64'h8);
      tick();
      check_output("unlocked sel_out", 64'(sel_out), 64'h3);
      check_output("unlocked data_out", data_out, pkt(8'h40, 1, 1));
      apply_stimulus(4'b0000, '0, '0, '0, '0);
      tick();

      // Asynchronous reset between sop and eop of req0
      apply_stimulus(4'b0001, pkt(8'h60, 1, 0), '0, '0, '0);
      check_output("rst sop ready_in", 64'(ready_in), 64'h1);
      tick();
      check_output("rst sop valid_out", 64'(valid_out), 64'h1);
      apply_stimulus(4'b1010, '0, pkt(8'h70, 1, 1), '0, pkt(8'h71, 1, 1));
      reset_n = 1'b0;
      #1;
      check_output("async valid_out", 64'(valid_out), 64'h0);
      check_output("async data_out", data_out, 64'h0);
      check_output("async ready_in", 64'(ready_in), 64'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      check_output("post reset ready_in", 64'(ready_in), 64'h2);
      tick();
      check_output("post reset sel_out", 64'(sel_out), 64'h1);
      check_output("post reset data_out", data_out, pkt(8'h70, 1, 1));

      $display("%0d/%0d checks passed", check_count - fail_count, check_count);
      $finish;
   end

endmodule
